// File: rtl/peridot_config_layer_if.sv
// Byte-stream valid/ready channel used by every port of peridot_config_layer.
// The master drives valid/data and the slave answers with ready.
interface peridot_config_layer_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/peridot_config_layer.sv
// peridot_config_layer: configuration-layer engine between the PERIDOT host
// byte link and the packet layer. It strips escape and configuration command
// bytes from the upstream stream, commits command payloads atomically to
// conf_out, and answers each command with a CONF_BYTES-long status response.
// Optional feature: define PERIDOT_CFG_TIMEOUT_EN to abandon a stalled payload
// after TIMEOUT_CYCLES idle cycles (pulsing conf_timeout).
module peridot_config_layer #(
    parameter int          CONF_BYTES     = 1,
    parameter logic [31:0] CONF_INIT      = 32'h0000_0039,
    parameter logic [7:0]  CMD_CODE       = 8'h3a,
    parameter logic [7:0]  ESC_CODE       = 8'h3d,
    parameter logic [7:0]  ESC_XOR        = 8'h20,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hffff
) (
    input  logic                      clk,
    input  logic                      reset,
    peridot_config_layer_if.slave     in_bus,
    peridot_config_layer_if.master    out_bus,
    peridot_config_layer_if.slave     pk_bus,
    peridot_config_layer_if.master    resp_bus,
    output logic [8*CONF_BYTES-1:0]   conf_out,
    input  logic [8*CONF_BYTES-1:0]   conf_in,
    output logic                      conf_update,
    output logic                      conf_timeout,
    output logic                      reset_request
);

    typedef enum logic [1:0] {IDLE, ESCAPE, CONFDATA, SENDRESP} state_t;

    localparam logic [1:0] LAST_IDX = 2'(CONF_BYTES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] shadow [4];
    logic [7:0] resp_q [4];
    logic       mode;
    logic       eff_ready;
    logic       is_special;
    logic       commit;
    logic       tmo_hit;

    // Bit 3 selects normal mode; in config mode pass-through bytes are sunk.
    assign mode          = conf_out[3];
    assign reset_request = ~conf_out[3];
    assign eff_ready     = mode ? out_bus.ready : 1'b1;
    assign commit        = (state == CONFDATA) && in_bus.valid && (idx == LAST_IDX);

    // Combinational pass-through and handshake steering for all four channels.
    always_comb begin
        is_special    = in_bus.valid && ((in_bus.data == CMD_CODE) || (in_bus.data == ESC_CODE));
        in_bus.ready  = eff_ready;
        out_bus.valid = 1'b0;
        out_bus.data  = in_bus.data;
        pk_bus.ready  = resp_bus.ready;
        resp_bus.valid = pk_bus.valid;
        resp_bus.data = pk_bus.data;
        case (state)
            IDLE: begin
                in_bus.ready  = is_special ? 1'b1 : eff_ready;
                out_bus.valid = in_bus.valid && !is_special && mode;
            end
            ESCAPE: begin
                out_bus.data  = in_bus.data ^ ESC_XOR;
                out_bus.valid = in_bus.valid && mode;
            end
            CONFDATA: begin
                in_bus.ready   = 1'b1;
                pk_bus.ready   = 1'b0;
                resp_bus.valid = 1'b0;
            end
            SENDRESP: begin
                in_bus.ready   = 1'b0;
                pk_bus.ready   = 1'b0;
                resp_bus.valid = 1'b1;
                resp_bus.data  = resp_q[idx];
            end
            default: ;
        endcase
    end

    // Protocol FSM: command/escape detection, payload collection, response walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            conf_out    <= CONF_INIT[8*CONF_BYTES-1:0];
            conf_update <= 1'b0;
            for (int b = 0; b < 4; b++) shadow[b] <= 8'h00;
        end else begin
            conf_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_bus.valid && (in_bus.data == CMD_CODE)) begin
                        state <= CONFDATA;
                        idx   <= 2'd0;
                    end else if (in_bus.valid && (in_bus.data == ESC_CODE)) begin
                        state <= ESCAPE;
                    end
                end
                ESCAPE: begin
                    if (in_bus.valid && eff_ready) state <= IDLE;
                end
                CONFDATA: begin
                    if (in_bus.valid) begin
                        shadow[idx] <= in_bus.data;
                        if (commit) begin
                            // Final byte bypasses the shadow so all bytes land together.
                            for (int b = 0; b < CONF_BYTES; b++)
                                conf_out[8*b +: 8] <= (b == CONF_BYTES - 1) ? in_bus.data : shadow[b[1:0]];
                            conf_update <= 1'b1;
                            state       <= SENDRESP;
                            idx         <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        idx   <= 2'd0;
                    end
                end
                SENDRESP: begin
                    if (resp_bus.ready) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            idx   <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status capture at commit; conf_in is asynchronous and this is its timing cut.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < CONF_BYTES; b++) resp_q[b[1:0]] <= conf_in[8*b +: 8];
        end
    end

`ifdef PERIDOT_CFG_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == CONFDATA) && !in_bus.valid && (tmo_cnt == TIMEOUT_CYCLES);

    // Inter-byte idle counter; held at zero outside CONFDATA and on each payload byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt      <= 16'd0;
            conf_timeout <= 1'b0;
        end else begin
            conf_timeout <= tmo_hit;
            if ((state != CONFDATA) || in_bus.valid) tmo_cnt <= 16'd0;
            else if (!tmo_hit)                       tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo   = ^TIMEOUT_CYCLES;
    assign tmo_hit      = 1'b0;
    assign conf_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_peridot_config_layer.sv
// Directed testbench for peridot_config_layer (CONF_BYTES=2 instance, plus a
// CONF_BYTES=3 / TIMEOUT_CYCLES=16 instance when PERIDOT_CFG_TIMEOUT_EN is set).
module tb_peridot_config_layer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    peridot_config_layer_if in_if();
    peridot_config_layer_if out_if();
    peridot_config_layer_if pk_if();
    peridot_config_layer_if resp_if();

    logic [15:0] conf_in;
    logic [15:0] conf_out;
    logic        conf_update;
    logic        conf_timeout;
    logic        reset_request;

    int checks = 0;
    int failures = 0;

    peridot_config_layer #(.CONF_BYTES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_bus        (in_if),
        .out_bus       (out_if),
        .pk_bus        (pk_if),
        .resp_bus      (resp_if),
        .conf_out      (conf_out),
        .conf_in       (conf_in),
        .conf_update   (conf_update),
        .conf_timeout  (conf_timeout),
        .reset_request (reset_request)
    );

`ifdef PERIDOT_CFG_TIMEOUT_EN
    peridot_config_layer_if t_in_if();
    peridot_config_layer_if t_out_if();
    peridot_config_layer_if t_pk_if();
    peridot_config_layer_if t_resp_if();
    logic [23:0] t_conf_in;
    logic [23:0] t_conf_out;
    logic        t_conf_update;
    logic        t_conf_timeout;
    logic        t_reset_request;

    peridot_config_layer #(.CONF_BYTES(3), .TIMEOUT_CYCLES(16'd16)) dut_tmo (
        .clk           (clk),
        .reset         (reset),
        .in_bus        (t_in_if),
        .out_bus       (t_out_if),
        .pk_bus        (t_pk_if),
        .resp_bus      (t_resp_if),
        .conf_out      (t_conf_out),
        .conf_in       (t_conf_in),
        .conf_update   (t_conf_update),
        .conf_timeout  (t_conf_timeout),
        .reset_request (t_reset_request)
    );
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a full 2-byte command and drain its response.
    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1);
        in_if.valid = 1'b1; in_if.data = 8'h3a; tick();
        in_if.data = b0; tick();
        in_if.data = b1; tick();
        in_if.valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset;
        repeat (3) tick();
        pk_if.valid = 1'b1; pk_if.data = 8'h77;
        #1;
        checks++; if (conf_out !== 16'h0039) begin failures++; $display("FAIL rst_conf_out got=%h exp=0039", conf_out); end
        checks++; if (conf_update !== 1'b0) begin failures++; $display("FAIL rst_conf_update got=%b exp=0", conf_update); end
        checks++; if (conf_timeout !== 1'b0) begin failures++; $display("FAIL rst_conf_timeout got=%b exp=0", conf_timeout); end
        checks++; if (reset_request !== 1'b0) begin failures++; $display("FAIL rst_reset_request got=%b exp=0", reset_request); end
        checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_if.valid); end
        checks++; if (resp_if.valid !== 1'b1 || resp_if.data !== 8'h77) begin failures++; $display("FAIL rst_resp_follow got=%b/%h exp=1/77", resp_if.valid, resp_if.data); end
        checks++; if (pk_if.ready !== 1'b1) begin failures++; $display("FAIL rst_pk_ready got=%b exp=1", pk_if.ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_config;
        int out_seen;
        logic [7:0] bytes [3];
        out_seen = 0;
        bytes[0] = 8'h3a; bytes[1] = 8'h12; bytes[2] = 8'h34;
        conf_in = 16'hA55A;
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1; in_if.data = bytes[i];
            @(negedge clk);
            checks++; if (in_if.ready !== 1'b1) begin failures++; $display("FAIL cfg_in_ready[%0d] got=%b exp=1", i, in_if.ready); end
            if (out_if.valid === 1'b1) out_seen++;
            if (i > 0) begin
                checks++; if (resp_if.valid !== 1'b0) begin failures++; $display("FAIL cfg_resp_blocked[%0d] got=%b exp=0", i, resp_if.valid); end
            end
            tick();
        end
        in_if.valid = 1'b0;
        checks++; if (conf_update !== 1'b1) begin failures++; $display("FAIL cfg_update got=%b exp=1", conf_update); end
        checks++; if (conf_out !== 16'h3412) begin failures++; $display("FAIL cfg_conf_out got=%h exp=3412", conf_out); end
        checks++; if (resp_if.valid !== 1'b1 || resp_if.data !== 8'h5a) begin failures++; $display("FAIL cfg_resp0 got=%b/%h exp=1/5a", resp_if.valid, resp_if.data); end
        tick();
        checks++; if (resp_if.valid !== 1'b1 || resp_if.data !== 8'ha5) begin failures++; $display("FAIL cfg_resp1 got=%b/%h exp=1/a5", resp_if.valid, resp_if.data); end
        checks++; if (conf_update !== 1'b0) begin failures++; $display("FAIL cfg_update_pulse got=%b exp=0", conf_update); end
        tick();
        checks++; if (resp_if.data !== 8'h77) begin failures++; $display("FAIL cfg_pk_resume got=%h exp=77", resp_if.data); end
        checks++; if (out_seen != 0) begin failures++; $display("FAIL cfg_no_forward got=%0d exp=0", out_seen); end
        checks++; if (reset_request !== 1'b1) begin failures++; $display("FAIL cfg_reset_request got=%b exp=1", reset_request); end
        pk_if.valid = 1'b0;
    endtask

    task automatic test_escape;
        logic [7:0] vin  [4];
        logic       vval [4];
        logic [7:0] vout [4];
        vin[0] = 8'h41; vval[0] = 1'b1; vout[0] = 8'h41;
        vin[1] = 8'h3d; vval[1] = 1'b0; vout[1] = 8'h00;
        vin[2] = 8'h1a; vval[2] = 1'b1; vout[2] = 8'h3a;
        vin[3] = 8'h42; vval[3] = 1'b1; vout[3] = 8'h42;
        send_cmd(8'h08, 8'h00);
        checks++; if (conf_out !== 16'h0008) begin failures++; $display("FAIL esc_conf_out got=%h exp=0008", conf_out); end
        checks++; if (reset_request !== 1'b0) begin failures++; $display("FAIL esc_reset_request got=%b exp=0", reset_request); end
        for (int i = 0; i < 4; i++) begin
            in_if.valid = 1'b1; in_if.data = vin[i];
            @(negedge clk);
            checks++; if (out_if.valid !== vval[i]) begin failures++; $display("FAIL esc_out_valid[%0d] got=%b exp=%b", i, out_if.valid, vval[i]); end
            if (vval[i]) begin
                checks++; if (out_if.data !== vout[i]) begin failures++; $display("FAIL esc_out_data[%0d] got=%h exp=%h", i, out_if.data, vout[i]); end
            end
            tick();
        end
        in_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_config_mode;
        logic [7:0] vin [2];
        vin[0] = 8'h55; vin[1] = 8'h66;
        send_cmd(8'h00, 8'h00);
        checks++; if (reset_request !== 1'b1) begin failures++; $display("FAIL mode_reset_request got=%b exp=1", reset_request); end
        out_if.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_if.valid = 1'b1; in_if.data = vin[i];
            @(negedge clk);
            checks++; if (in_if.ready !== 1'b1) begin failures++; $display("FAIL mode_sink_ready[%0d] got=%b exp=1", i, in_if.ready); end
            checks++; if (out_if.valid !== 1'b0) begin failures++; $display("FAIL mode_out_valid[%0d] got=%b exp=0", i, out_if.valid); end
            tick();
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        tick();
    endtask

    task automatic test_stall;
        conf_in = 16'h1E2D;
        pk_if.valid = 1'b1; pk_if.data = 8'hc3;
        in_if.valid = 1'b1; in_if.data = 8'h3a; tick();
        in_if.data = 8'h08; tick();
        checks++; if (pk_if.ready !== 1'b0) begin failures++; $display("FAIL stall_pk_ready_cfg got=%b exp=0", pk_if.ready); end
        resp_if.ready = 1'b0;
        in_if.data = 8'h00; tick();
        in_if.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_if.valid !== 1'b1 || resp_if.data !== 8'h2d) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/2d", i, resp_if.valid, resp_if.data); end
            checks++; if (pk_if.ready !== 1'b0) begin failures++; $display("FAIL stall_pk_ready[%0d] got=%b exp=0", i, pk_if.ready); end
            tick();
        end
        resp_if.ready = 1'b1;
        tick();
        checks++; if (resp_if.valid !== 1'b1 || resp_if.data !== 8'h1e) begin failures++; $display("FAIL stall_resp1 got=%b/%h exp=1/1e", resp_if.valid, resp_if.data); end
        checks++; if (pk_if.ready !== 1'b0) begin failures++; $display("FAIL stall_pk_ready_last got=%b exp=0", pk_if.ready); end
        tick();
        checks++; if (pk_if.ready !== 1'b1 || resp_if.data !== 8'hc3) begin failures++; $display("FAIL stall_pk_resume got=%b/%h exp=1/c3", pk_if.ready, resp_if.data); end
        pk_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        in_if.valid = 1'b1; in_if.data = 8'h3a; tick();
        in_if.data = 8'h01; tick();
        in_if.valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        checks++; if (conf_out !== 16'h0039) begin failures++; $display("FAIL rmid_conf_out got=%h exp=0039", conf_out); end
        checks++; if (conf_update !== 1'b0) begin failures++; $display("FAIL rmid_update got=%b exp=0", conf_update); end
        in_if.valid = 1'b1; in_if.data = 8'h41;
        @(negedge clk);
        checks++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h41) begin failures++; $display("FAIL rmid_forward got=%b/%h exp=1/41", out_if.valid, out_if.data); end
        checks++; if (resp_if.valid !== 1'b0) begin failures++; $display("FAIL rmid_resp_dropped got=%b exp=0", resp_if.valid); end
        tick();
        in_if.valid = 1'b0;
        tick();
    endtask

`ifdef PERIDOT_CFG_TIMEOUT_EN
    task automatic test_timeout;
        int pulses;
        bit seen;
        pulses = 0; seen = 1'b0;
        t_in_if.valid = 1'b1; t_in_if.data = 8'h3a; tick();
        t_in_if.data = 8'h01; tick();
        t_in_if.valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (t_conf_timeout === 1'b1) begin pulses++; seen = 1'b1; end
            else if (seen) break;
            tick();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL tmo_pulse got=%0d exp=1", pulses); end
        checks++; if (t_conf_out !== 24'h000039) begin failures++; $display("FAIL tmo_conf_out got=%h exp=000039", t_conf_out); end
        checks++; if (t_conf_update !== 1'b0 || t_resp_if.valid !== 1'b0) begin failures++; $display("FAIL tmo_no_commit got=%b/%b exp=0/0", t_conf_update, t_resp_if.valid); end
        t_in_if.valid = 1'b1; t_in_if.data = 8'h41;
        @(negedge clk);
        checks++; if (t_out_if.valid !== 1'b1 || t_out_if.data !== 8'h41) begin failures++; $display("FAIL tmo_forward got=%b/%h exp=1/41", t_out_if.valid, t_out_if.data); end
        tick();
        t_in_if.valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.valid = 1'b0; in_if.data = 8'h00;
        out_if.ready = 1'b1;
        pk_if.valid = 1'b0; pk_if.data = 8'h00;
        resp_if.ready = 1'b1;
        conf_in = 16'h0000;
`ifdef PERIDOT_CFG_TIMEOUT_EN
        t_in_if.valid = 1'b0; t_in_if.data = 8'h00;
        t_out_if.ready = 1'b1;
        t_pk_if.valid = 1'b0; t_pk_if.data = 8'h00;
        t_resp_if.ready = 1'b1;
        t_conf_in = 24'h000000;
`endif
        test_reset();
        test_config();
        test_escape();
        test_config_mode();
        test_stall();
        test_reset_mid();
`ifdef PERIDOT_CFG_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
